xylo_player: RTL and testbench

XYLO_PLAYER -- requirements
Module: xylo_player

---
 rtl/xylo_pkg.sv | 27 ++
 rtl/xylo_fifo.sv | 75 +++++++
 rtl/xylo_player.sv | 135 +++++++++++++
 tb/tb_xylo_player.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/xylo_pkg.sv
// ---------------------------------------------------------------------------
// xylo_pkg -- shared definitions for the xylophone note player.
//
// Holds the player FSM state encoding, the default values of the player's
// parameters, and a small helper that sizes the hold/gap cycle counter.
// ---------------------------------------------------------------------------
package xylo_pkg;

  localparam int DEF_NUM_BARS = 7;  // one strike output per bar
  localparam int DEF_NOTE_W   = 3;  // note code width; codes >= NUM_BARS are rests
  localparam int DEF_DEPTH    = 8;  // note FIFO depth (power of two)
  localparam int DEF_HOLD_CYC = 4;  // cycles a bar stays struck (or a rest lasts)
  localparam int DEF_GAP_CYC  = 2;  // silent cycles after every note or rest

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STRIKE,
    ST_REST,
    ST_GAP
  } state_t;

  // Counter width able to hold values 0 .. max_cyc-1 (at least one bit).
  function automatic int cnt_width(input int max_cyc);
    return (max_cyc > 1) ? $clog2(max_cyc) : 1;
  endfunction

endpackage

// File: rtl/xylo_fifo.sv
// ---------------------------------------------------------------------------
// xylo_fifo -- synchronous FIFO holding queued notes for the player.
//
// Ports:
//   clock    in   single clock, rising edge
//   reset_n  in   asynchronous active-low reset (empties the FIFO)
//   push     in   write din this cycle (ignored while full)
//   din      in   entry to write {tom, code}
//   pop      in   drop the head entry this cycle (ignored while empty)
//   dout     out  head entry (valid while not empty)
//   nivel    out  current occupancy, 0 .. DEPTH
//   full     out  nivel == DEPTH
//   empty    out  nivel == 0
//
// Simultaneous push and pop leave nivel unchanged, so a note written in the
// same cycle the last entry is read out is kept.
// ---------------------------------------------------------------------------
module xylo_fifo
  import xylo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_NOTE_W + 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   nivel,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: all sequential state is updated with non-blocking assignments so
  // every register sees the pre-edge value of every other register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      nivel  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   nivel <= nivel + 1'b1;
        2'b01:   nivel <= nivel - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only ever read after
  // being written, and the empty pointers already make stale data invisible.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (nivel == (AW + 1)'(DEPTH));
  assign empty = (nivel == '0);

endmodule

// File: rtl/xylo_player.sv
// ---------------------------------------------------------------------------
// xylo_player -- plays queued notes on a bank of xylophone bars.
//
// Ports:
//   clock     in   single clock, rising edge
//   reset_n   in   asynchronous active-low reset; aborts playback and
//                  discards every queued note
//   tom       in   tone of the offered note (0 low, 1 high)
//   notas     in   note code; 0..NUM_BARS-1 strike a bar, others are rests
//   in_valid  in   tom/notas hold a note to enqueue
//   in_ready  out  FIFO can take a note this cycle (nivel < DEPTH)
//   saidas    out  one-hot strike vector, zero when silent (registered)
//   tom_out   out  tone of the note being struck, zero when silent (reg.)
//   busy      out  FSM is not idle (registered)
//   nivel     out  FIFO occupancy
//
// Each note occupies HOLD_CYC cycles (STRIKE or REST) followed by GAP_CYC
// silent cycles. The last GAP cycle pops the next note straight into
// STRIKE/REST, so back-to-back notes repeat every HOLD_CYC+GAP_CYC cycles.
// saidas/tom_out are registered from the current state, so the strike
// appears one edge after the FSM enters STRIKE: two edges after a push into
// an empty, idle player.
// ---------------------------------------------------------------------------
module xylo_player
  import xylo_pkg::*;
#(
  parameter int NUM_BARS = DEF_NUM_BARS,
  parameter int NOTE_W   = DEF_NOTE_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  parameter int GAP_CYC  = DEF_GAP_CYC
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   tom,
  input  logic [NOTE_W-1:0]      notas,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [NUM_BARS-1:0]    saidas,
  output logic                   tom_out,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] nivel
);

  localparam int MAX_CYC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int CNT_W   = cnt_width(MAX_CYC);
  localparam int ENTRY_W = NOTE_W + 1;

  state_t              state;
  logic [CNT_W-1:0]    cnt;        // cycles left in the current phase, minus one
  logic [NOTE_W-1:0]   cur_code;
  logic                cur_tom;

  logic [ENTRY_W-1:0]  head;
  logic                head_tom;
  logic [NOTE_W-1:0]   head_code;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;

  function automatic logic is_bar(input logic [NOTE_W-1:0] code);
    return int'(code) < NUM_BARS;
  endfunction

  xylo_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (in_valid),
    .din     ({tom, notas}),
    .pop     (pop),
    .dout    (head),
    .nivel   (nivel),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign {head_tom, head_code} = head;
  assign in_ready = !fifo_full;

  // A note is taken from the FIFO either from IDLE or on the final GAP cycle.
  assign pop = !fifo_empty &&
               ((state == ST_IDLE) || ((state == ST_GAP) && (cnt == '0)));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cur_code <= '0;
      cur_tom  <= 1'b0;
      saidas   <= '0;
      tom_out  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      saidas  <= (state == ST_STRIKE) ? (NUM_BARS'(1) << cur_code) : '0;
      tom_out <= (state == ST_STRIKE) && cur_tom;

      if (pop) begin
        state    <= is_bar(head_code) ? ST_STRIKE : ST_REST;
        cnt      <= CNT_W'(HOLD_CYC - 1);
        cur_code <= head_code;
        cur_tom  <= head_tom;
        busy     <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_STRIKE, ST_REST: begin
            if (cnt == '0) begin
              state <= ST_GAP;
              cnt   <= CNT_W'(GAP_CYC - 1);
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_GAP: begin
            // Reaching zero here without a pop means the FIFO is empty.
            if (cnt == '0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xylo_player.sv
// ---------------------------------------------------------------------------
// tb_xylo_player -- directed self-checking bench for xylo_player (defaults:
// 7 bars, 3-bit codes, depth 8, hold 4, gap 2).
//
// Each scenario starts from an idle player, fills a per-cycle stimulus table
// and a list of the notes expected to play, then steps the clock. Expected
// outputs come from the timing rules: cycle t counts edges from the first
// push; notes pop at t = 1 + 6k, strike visibly on t = 2+6k .. 5+6k, and the
// player is busy from t = 1 until t = 1 + 6*notes.
// ---------------------------------------------------------------------------
module tb_xylo_player;

  localparam int NB    = 7;
  localparam int NW    = 3;
  localparam int DEP   = 8;
  localparam int PER   = 6;  // hold + gap
  localparam int HOLD  = 4;
  localparam int MAXT  = 64;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              tom = 1'b0;
  logic [NW-1:0]     notas = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NB-1:0]     saidas;
  logic              tom_out;
  logic              busy;
  logic [3:0]        nivel;

  int checks = 0;
  int failures = 0;

  logic          stim_valid [MAXT];
  logic [NW-1:0] stim_code  [MAXT];
  logic          stim_tom   [MAXT];
  int            note_code  [16];
  logic          note_tom   [16];

  xylo_player dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .tom      (tom),
    .notas    (notas),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .saidas   (saidas),
    .tom_out  (tom_out),
    .busy     (busy),
    .nivel    (nivel)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < MAXT; i++) begin
      stim_valid[i] = 1'b0;
      stim_code[i]  = '0;
      stim_tom[i]   = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      note_code[i] = 0;
      note_tom[i]  = 1'b0;
    end
  endtask

  task automatic push_at(input int t, input int code, input logic tv);
    stim_valid[t] = 1'b1;
    stim_code[t]  = NW'(code);
    stim_tom[t]   = tv;
  endtask

  task automatic expect_note(input int k, input int code, input logic tv);
    note_code[k] = code;
    note_tom[k]  = tv;
  endtask

  // Steps n cycles from an idle, empty player; n_notes notes are expected to
  // play back to back in note_code order.
  task automatic run(input string name, input int n, input int n_notes);
    int lvl;
    int k;
    int ph;
    int exp_s;
    logic exp_t;
    logic exp_b;
    logic push_ok;
    logic pop_now;
    lvl = 0;
    for (int t = 0; t < n; t++) begin
      in_valid = stim_valid[t];
      notas    = stim_code[t];
      tom      = stim_tom[t];
      @(posedge clock);
      #1;
      push_ok = stim_valid[t] && (lvl < DEP);
      pop_now = (t >= 1) && ((t - 1) % PER == 0) && ((t - 1) / PER < n_notes);
      lvl = lvl + int'(push_ok) - int'(pop_now);
      exp_s = 0;
      exp_t = 1'b0;
      if (t >= 2) begin
        k  = (t - 2) / PER;
        ph = (t - 2) % PER;
        if ((k < n_notes) && (ph < HOLD) && (note_code[k] < NB)) begin
          exp_s = 1 << note_code[k];
          exp_t = note_tom[k];
        end
      end
      exp_b = (t >= 1) && (t < 1 + PER * n_notes);
      check($sformatf("%s saidas t=%0d", name, t), 32'(saidas), exp_s);
      check($sformatf("%s tom_out t=%0d", name, t), 32'(tom_out), 32'(exp_t));
      check($sformatf("%s busy t=%0d", name, t), 32'(busy), 32'(exp_b));
      check($sformatf("%s nivel t=%0d", name, t), 32'(nivel), lvl);
      check($sformatf("%s in_ready t=%0d", name, t), 32'(in_ready), 32'(lvl < DEP));
    end
    in_valid = 1'b0;
    notas    = '0;
    tom      = 1'b0;
  endtask

  initial begin
    // Reset state, checked while reset is held.
    #2;
    check("reset saidas", 32'(saidas), 0);
    check("reset tom_out", 32'(tom_out), 0);
    check("reset busy", 32'(busy), 0);
    check("reset nivel", 32'(nivel), 0);
    check("reset in_ready", 32'(in_ready), 1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Single note: tom=1, code 2 -> bar 2 high-tone strike.
    clear_stim();
    push_at(0, 2, 1'b1);
    expect_note(0, 2, 1'b1);
    run("single", 9, 1);

    // Burst of codes 0..6 pushed on consecutive cycles, alternating tone.
    clear_stim();
    for (int i = 0; i < 7; i++) begin
      push_at(i, i, 1'(i & 1));
      expect_note(i, i, 1'(i & 1));
    end
    run("burst", 46, 7);

    // Rest between two notes; the rest carries tom=1 but stays silent.
    clear_stim();
    push_at(0, 1, 1'b1);
    push_at(1, 7, 1'b1);
    push_at(2, 3, 1'b0);
    expect_note(0, 1, 1'b1);
    expect_note(1, 7, 1'b1);
    expect_note(2, 3, 1'b0);
    run("rest", 22, 3);

    // Push coinciding with the pop of the last queued entry (t=7).
    clear_stim();
    push_at(0, 5, 1'b0);
    push_at(1, 6, 1'b1);
    push_at(7, 0, 1'b1);
    expect_note(0, 5, 1'b0);
    expect_note(1, 6, 1'b1);
    expect_note(2, 0, 1'b1);
    run("lastpop", 22, 3);

    // in_valid held for 12 cycles: FIFO fills at t=9, t=10/11 are refused.
    clear_stim();
    for (int i = 0; i < 12; i++) push_at(i, i % 7, 1'b0);
    for (int i = 0; i < 10; i++) expect_note(i, i % 7, 1'b0);
    run("full", 64, 10);

    // Reset during a strike with three notes still queued.
    clear_stim();
    push_at(0, 4, 1'b1);
    push_at(1, 5, 1'b1);
    push_at(2, 6, 1'b1);
    push_at(3, 0, 1'b1);
    expect_note(0, 4, 1'b1);
    run("prereset", 5, 4);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset saidas", 32'(saidas), 0);
    check("midreset tom_out", 32'(tom_out), 0);
    check("midreset busy", 32'(busy), 0);
    check("midreset nivel", 32'(nivel), 0);
    check("midreset in_ready", 32'(in_ready), 1);
    #2;
    reset_n = 1'b1;
    clear_stim();
    run("postreset", 20, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
